// File: rtl/candy_rng.sv
// Galois LFSR random source with zero-seed guard, plus a rejection-sampled
// colour generator that hands out one index per request over valid/ready.
module candy_rng #(
   parameter int                WIDTH      = 16,
   parameter logic [WIDTH-1:0]  TAPS       = 16'hB400,
   parameter logic [WIDTH-1:0]  SEED       = 16'hACE1,
   parameter int                NUM_COLORS = 6,
   parameter int                COLOR_W    = 3,
   parameter int                MAX_TRIES  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               seed_load,
   input  logic [WIDTH-1:0]   seed_in,
   input  logic               color_req,
   output logic               color_valid,
   input  logic               color_ready,
   output logic [COLOR_W-1:0] color_out,
   output logic [WIDTH-1:0]   rand_out,
   output logic               busy,
   output logic               lockup
);

   localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_W-1:0]   TRY_LAST = TRY_W'(MAX_TRIES - 1);
   localparam logic [COLOR_W:0]   NUM_WIDE = (COLOR_W + 1)'(NUM_COLORS);
   localparam logic [COLOR_W-1:0] NUM_FOLD = COLOR_W'(NUM_COLORS);

   typedef enum logic [1:0] {IDLE, DRAW, HOLD} fsm_t;

   fsm_t               fsm;
   logic [WIDTH-1:0]   state;
   logic [TRY_W-1:0]   tries;
   logic [COLOR_W-1:0] cand;
   logic               cand_ok;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : '0);
   endfunction

   // Candidate always comes from the state before this cycle's step or load.
   assign cand     = state[COLOR_W-1:0];
   assign cand_ok  = ({1'b0, cand} < NUM_WIDE);
   assign rand_out = state;
   assign busy     = (fsm != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SEED;
         fsm         <= IDLE;
         tries       <= '0;
         color_valid <= 1'b0;
         color_out   <= '0;
         lockup      <= 1'b0;
      end else begin
         lockup <= 1'b0;
         if (seed_load) begin
            if (seed_in != '0) begin
               state <= seed_in;
            end else begin
               state  <= SEED;
               lockup <= 1'b1;
            end
         end else if ((fsm == IDLE && enable) || fsm == DRAW) begin
            state <= lfsr_step(state);
         end

         case (fsm)
            IDLE: begin
               if (color_req) begin
                  fsm   <= DRAW;
                  tries <= '0;
               end
            end
            DRAW: begin
               if (cand_ok) begin
                  color_out   <= cand;
                  color_valid <= 1'b1;
                  fsm         <= HOLD;
               end else if (tries == TRY_LAST) begin
                  // Out of retries: fold the out-of-range candidate back into range.
                  color_out   <= cand - NUM_FOLD;
                  color_valid <= 1'b1;
                  fsm         <= HOLD;
               end else begin
                  tries <= tries + 1'b1;
               end
            end
            HOLD: begin
               if (color_ready) begin
                  color_valid <= 1'b0;
                  fsm         <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_candy_rng.sv
// Bench for candy_rng: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a cycle-level behavioural model.
module tb_candy_rng;

   localparam int WIDTH      = 16;
   localparam int TAPS       = 'hB400;
   localparam int SEED       = 'hACE1;
   localparam int NUM_COLORS = 6;
   localparam int COLOR_W    = 3;
   localparam int MAX_TRIES  = 4;
   localparam int CMASK      = (1 << COLOR_W) - 1;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               enable = 1'b0;
   logic               seed_load = 1'b0;
   logic [WIDTH-1:0]   seed_in = '0;
   logic               color_req = 1'b0;
   logic               color_valid;
   logic               color_ready = 1'b0;
   logic [COLOR_W-1:0] color_out;
   logic [WIDTH-1:0]   rand_out;
   logic               busy;
   logic               lockup;

   int checks = 0;
   int errors = 0;

   candy_rng #(
      .WIDTH(WIDTH), .TAPS(16'hB400), .SEED(16'hACE1),
      .NUM_COLORS(NUM_COLORS), .COLOR_W(COLOR_W), .MAX_TRIES(MAX_TRIES)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
      .seed_in(seed_in), .color_req(color_req), .color_valid(color_valid),
      .color_ready(color_ready), .color_out(color_out), .rand_out(rand_out),
      .busy(busy), .lockup(lockup)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned nxt(input int unsigned s);
      return (s >> 1) ^ (((s & 1) != 0) ? TAPS : 0);
   endfunction

   // Behavioural model: phase 0 = waiting, 1 = drawing, 2 = holding a result.
   int unsigned m_state = SEED;
   int unsigned m_color = 0;
   int unsigned m_cand  = 0;
   int          m_phase = 0;
   int          m_ph    = 0;
   int          m_tries = 0;
   bit          m_valid = 0;
   bit          m_lock  = 0;
   bit          model_ok = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_state = SEED; m_phase = 0; m_tries = 0;
         m_valid = 0; m_color = 0; m_lock = 0;
         model_ok = 1;
      end else if (model_ok) begin
         m_cand = m_state & CMASK;
         m_ph   = m_phase;
         m_lock = 0;
         if (seed_load) begin
            if (seed_in != 0) m_state = 32'(seed_in);
            else begin m_state = SEED; m_lock = 1; end
         end else if ((m_ph == 0 && enable) || m_ph == 1) begin
            m_state = nxt(m_state);
         end
         if (m_ph == 0) begin
            if (color_req) begin m_phase = 1; m_tries = 0; end
         end else if (m_ph == 1) begin
            if (m_cand < NUM_COLORS) begin
               m_color = m_cand; m_valid = 1; m_phase = 2;
            end else if (m_tries == MAX_TRIES - 1) begin
               m_color = (m_cand - NUM_COLORS) & CMASK; m_valid = 1; m_phase = 2;
            end else begin
               m_tries++;
            end
         end else begin
            if (color_ready) begin m_valid = 0; m_phase = 0; end
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("model rand_out",    32'(rand_out),    m_state);
         chk("model color_valid", 32'(color_valid), 32'(m_valid));
         chk("model color_out",   32'(color_out),   m_color);
         chk("model busy",        32'(busy),        32'(m_phase != 0));
         chk("model lockup",      32'(lockup),      32'(m_lock));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic handshake();
      color_ready = 1'b1;
      tick();
      color_ready = 1'b0;
      chk("handshake valid drop", 32'(color_valid), 0);
   endtask

   int unsigned found_seed;
   int unsigned fold_exp;
   int unsigned s;
   int unsigned hold_color;
   int unsigned hold_rand;
   int          zero_hits;
   int          early_hits;
   int          unstable;

   initial begin
      // Reset state
      tick(); tick();
      chk("reset rand_out", 32'(rand_out), 'hACE1);
      chk("reset valid", 32'(color_valid), 0);
      chk("reset color_out", 32'(color_out), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset lockup", 32'(lockup), 0);

      // Scenario 1: request with enable low, best-case latency
      reset = 1'b0;
      color_req = 1'b1;
      tick();
      color_req = 1'b0;
      chk("s1 t+1 busy", 32'(busy), 1);
      chk("s1 t+1 valid", 32'(color_valid), 0);
      tick();
      chk("s1 t+2 valid", 32'(color_valid), 1);
      chk("s1 t+2 color", 32'(color_out), 1);
      chk("s1 t+2 rand", 32'(rand_out), 'hE270);
      tick();
      chk("s1 t+3 rand held", 32'(rand_out), 'hE270);
      handshake();
      enable = 1'b1;
      tick();
      enable = 1'b0;
      chk("s1 next step", 32'(rand_out), 'h7138);

      // Scenario 2: free run from reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      enable = 1'b1;
      chk("s2 step0", 32'(rand_out), 'hACE1);
      tick(); chk("s2 step1", 32'(rand_out), 'hE270);
      tick(); chk("s2 step2", 32'(rand_out), 'h7138);
      tick(); chk("s2 step3", 32'(rand_out), 'h389C);
      enable = 1'b0;

      // Scenario 3: one rejection then accept
      seed_load = 1'b1; seed_in = 16'h0007;
      tick();
      seed_load = 1'b0;
      chk("s3 seed", 32'(rand_out), 'h0007);
      color_req = 1'b1;
      tick();
      color_req = 1'b0;
      tick();
      chk("s3 after reject", 32'(rand_out), 'hB403);
      chk("s3 t+2 valid", 32'(color_valid), 0);
      tick();
      chk("s3 t+3 valid", 32'(color_valid), 1);
      chk("s3 color", 32'(color_out), 3);
      handshake();

      // Scenario 4: four rejections in a row force a fold
      found_seed = 0;
      for (int unsigned c = 1; c < 65536 && found_seed == 0; c++) begin
         s = c;
         if ((s & CMASK) >= NUM_COLORS && (nxt(s) & CMASK) >= NUM_COLORS &&
             (nxt(nxt(s)) & CMASK) >= NUM_COLORS &&
             (nxt(nxt(nxt(s))) & CMASK) >= NUM_COLORS) begin
            found_seed = c;
            fold_exp = (nxt(nxt(nxt(s))) & CMASK) - NUM_COLORS;
         end
      end
      if (found_seed == 0) begin
         checks++; errors++;
         $display("FAIL s4 seed search: no seed found, expected one");
      end else begin
         seed_load = 1'b1; seed_in = found_seed[WIDTH-1:0];
         tick();
         seed_load = 1'b0;
         color_req = 1'b1;
         tick();
         color_req = 1'b0;
         tick(); tick(); tick();
         chk("s4 t+4 valid", 32'(color_valid), 0);
         tick();
         chk("s4 t+5 valid", 32'(color_valid), 1);
         chk("s4 folded color", 32'(color_out), fold_exp);
         handshake();
      end

      // Scenario 5: zero seed guard and full period
      seed_load = 1'b1; seed_in = '0;
      tick();
      seed_load = 1'b0;
      chk("s5 fallback seed", 32'(rand_out), 'hACE1);
      chk("s5 lockup pulse", 32'(lockup), 1);
      enable = 1'b1;
      tick();
      chk("s5 lockup clears", 32'(lockup), 0);
      zero_hits = 0; early_hits = 0;
      for (int i = 1; i < 65535; i++) begin
         if (rand_out == '0) zero_hits++;
         if (rand_out == 16'hACE1) early_hits++;
         tick();
      end
      enable = 1'b0;
      chk("s5 zero states seen", 32'(zero_hits), 0);
      chk("s5 early returns", 32'(early_hits), 0);
      chk("s5 period return", 32'(rand_out), 'hACE1);

      // Scenario 6: stall in HOLD, then reset mid-HOLD
      color_req = 1'b1;
      tick();
      color_req = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < MAX_TRIES + 3 && !color_valid; i++) tick();
      chk("s6 valid within bound", 32'(color_valid), 1);
      hold_color = 32'(color_out);
      hold_rand  = 32'(rand_out);
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (32'(color_out) != hold_color || 32'(rand_out) != hold_rand || !color_valid)
            unstable++;
      end
      chk("s6 hold stable", 32'(unstable), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      enable = 1'b0;
      chk("s6 reset valid", 32'(color_valid), 0);
      chk("s6 reset busy", 32'(busy), 0);
      chk("s6 reset rand", 32'(rand_out), 'hACE1);
      chk("s6 reset color", 32'(color_out), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 299) == 0);
         seed_load   = ($urandom_range(0, 19) == 0);
         seed_in     = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
         enable      = $urandom_range(0, 1) == 1;
         color_req   = $urandom_range(0, 9) < 3;
         color_ready = $urandom_range(0, 9) < 4;
         tick();
      end
      reset = 1'b0; seed_load = 1'b0; color_req = 1'b0; color_ready = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
